cache: RTL and testbench
========================

// Module: cache
// PURPOSE
//  Standalone 4-line, fully associative, write-allocate data cache with word and byte access.
//  Serves a single load/store port on one clock and reports hit/miss per access.
//  Has no backing-memory port: evictions discard the line; a read miss returns zero.
//  Sits beside the core's load/store unit as the L1 data store.
// PARAMETERS
//  ADDRESS_WIDTH   32  byte-address width
//  WORD_WIDTH      32  data word width (4 bytes)
//  WORDS_PER_LINE  4   words per line (16-byte line)
//  NUM_LINES       4   lines; fully associative
// PORTS
//  clk       in   1   clock, rising edge active
//  reset     in   1   asynchronous, active-high reset
//  access    in   1   request valid, sampled on each rising edge
//  address   in   32  byte address
//  byteOP    in   1   1 = byte access, 0 = word access
//  data_in   in   32  write data; byte writes use [7:0]
//  op        in   1   0 = write, 1 = read
//  data_out  out  32  read data (registered)
//  hit       out  1   registered: last sampled access hit
//  miss      out  1   registered: last sampled access missed
// BEHAVIOUR
//  - Address split: tag = address[31:4], word = address[3:2], byte = address[1:0].
//  - Word accesses ignore address[1:0].
//  - Reset (async, any time, including mid-access):
//    - all lines invalid; data and tags cleared to 0; LRU ages set to 0,1,2,3.
//    - data_out = 0, hit = 0, miss = 0.
//  - Each rising edge with access = 1 performs one operation; outputs update on that edge (1-cycle latency).
//  - Edge with access = 0: hit = miss = 0; data_out holds its value; no state change.
//  - Lookup: hit when any valid line's tag equals address[31:4]. At most one line can match.
//  - Read hit:
//    - word: data_out = stored word.
//    - byte: data_out = {24'b0, selected byte}.
//    - hit = 1; the hit line becomes MRU.
//  - Read miss: data_out = 0, miss = 1; no allocation; LRU unchanged.
//  - Write hit: store data_in (word) or data_in[7:0] (byte) into the addressed word/byte; hit = 1; line becomes MRU.
//  - Write miss (allocate): victim = first invalid line (lowest index), else the LRU line.
//    - Victim gets the new tag, valid = 1; all its words are zeroed, then the write is merged.
//    - miss = 1; the victim becomes MRU.
//  - Access held for several cycles: repeats every edge. A write repeats idempotently and reports hit from its 2nd cycle on.
//  - LRU: 2-bit age per line.
//    - On use, lines younger than the used line age by +1; the used line goes to 0.
//    - Ages stay a permutation of 0..3.
//  - hit and miss are never both 1.
// STRUCTURE
//  - cache_pkg: line/tag/offset widths, NUM_LINES, op encodings (OP_WRITE = 0, OP_READ = 1).
//  - Sub-module cache_lru: age array, victim select, MRU update.
//  - Top: tag compare, data array, byte-lane merge/extract.
// TESTING
//  1. Reset, then word write 0x00000011 to 0x4 (access held 2 cycles) -> cycle 1 miss = 1, cycle 2 hit = 1.
//  2. Word read 0x4 -> hit = 1, data_out = 0x00000011; byte read 0x4 -> data_out = 0x00000011.
//  3. Byte write 0x22 to 0x6, then word read 0x4 -> data_out = 0x00220011; read 0x0 -> 0x00000000 (hit).
//  4. Word writes to 0x00, 0x10, 0x20, 0x30, then 0x40 -> line 0x00 evicted; read 0x0 -> miss = 1, data_out = 0.
//  5. Writes to 0x00/0x10/0x20/0x30, read 0x00, write 0x40 -> line 0x10 evicted; read 0x00 still hits.
//  6. Assert reset mid-access -> outputs 0 immediately; read 0x4 afterwards -> miss = 1, data_out = 0.

Source files
------------

// File: rtl/cache_pkg.sv
// rtl/cache_pkg.sv - shared widths, index/age types and op encodings for the data cache
package cache_pkg;

    localparam int ADDRESS_WIDTH  = 32;
    localparam int WORD_WIDTH     = 32;
    localparam int WORDS_PER_LINE = 4;
    localparam int NUM_LINES      = 4;

    localparam int BYTE_SEL_WIDTH = 2;
    localparam int WORD_SEL_WIDTH = $clog2(WORDS_PER_LINE);
    localparam int OFFSET_WIDTH   = BYTE_SEL_WIDTH + WORD_SEL_WIDTH;
    localparam int TAG_WIDTH      = ADDRESS_WIDTH - OFFSET_WIDTH;
    localparam int LINE_IDX_WIDTH = $clog2(NUM_LINES);
    localparam int AGE_WIDTH      = LINE_IDX_WIDTH;

    typedef enum logic {
        OP_WRITE = 1'b0,
        OP_READ  = 1'b1
    } op_e;

    typedef logic [TAG_WIDTH-1:0]      tag_t;
    typedef logic [WORD_WIDTH-1:0]     word_t;
    typedef logic [LINE_IDX_WIDTH-1:0] line_idx_t;
    typedef logic [WORD_SEL_WIDTH-1:0] word_sel_t;
    typedef logic [BYTE_SEL_WIDTH-1:0] byte_sel_t;
    typedef logic [AGE_WIDTH-1:0]      age_t;

    localparam age_t AGE_OLDEST = age_t'(NUM_LINES - 1);

endpackage

// File: rtl/cache_lru.sv
// rtl/cache_lru.sv - per-line age tracking, victim selection and MRU update
module cache_lru
    import cache_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 touch,
    input  line_idx_t            touch_line,
    input  logic [NUM_LINES-1:0] valid,
    output line_idx_t            victim
);

    age_t age [NUM_LINES];
    logic found_invalid;

    // Invalid lines are preferred (lowest index first); otherwise the oldest line.
    always_comb begin
        victim        = '0;
        found_invalid = 1'b0;
        for (int i = 0; i < NUM_LINES; i++) begin
            if (!valid[i] && !found_invalid) begin
                victim        = line_idx_t'(i);
                found_invalid = 1'b1;
            end
        end
        if (!found_invalid) begin
            for (int i = 0; i < NUM_LINES; i++) begin
                if (age[i] == AGE_OLDEST) begin
                    victim = line_idx_t'(i);
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_LINES; i++) begin
                age[i] <= age_t'(i);
            end
        end else if (touch) begin
            for (int i = 0; i < NUM_LINES; i++) begin
                if (line_idx_t'(i) == touch_line) begin
                    age[i] <= '0;
                end else if (age[i] < age[touch_line]) begin
                    age[i] <= age[i] + age_t'(1);
                end
            end
        end
    end

endmodule

// File: rtl/cache.sv
// rtl/cache.sv - 4-line fully associative write-allocate data cache, word/byte access
module cache
    import cache_pkg::*;
(
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     access,
    input  logic [ADDRESS_WIDTH-1:0] address,
    input  logic                     byteOP,
    input  logic [WORD_WIDTH-1:0]    data_in,
    input  logic                     op,
    output logic [WORD_WIDTH-1:0]    data_out,
    output logic                     hit,
    output logic                     miss
);

    tag_t                 tags  [NUM_LINES];
    word_t                data  [NUM_LINES][WORDS_PER_LINE];
    logic [NUM_LINES-1:0] valid;

    tag_t      addr_tag;
    word_sel_t word_sel;
    byte_sel_t byte_sel;
    logic      is_read;

    assign addr_tag = address[ADDRESS_WIDTH-1:OFFSET_WIDTH];
    assign word_sel = address[OFFSET_WIDTH-1:BYTE_SEL_WIDTH];
    assign byte_sel = address[BYTE_SEL_WIDTH-1:0];
    assign is_read  = (op_e'(op) == OP_READ);

    logic      any_hit;
    line_idx_t hit_idx;
    line_idx_t victim;
    line_idx_t target_line;
    word_t     stored_word;
    word_t     base_word;
    word_t     merged_word;
    word_t     read_word;

    always_comb begin
        any_hit = 1'b0;
        hit_idx = '0;
        for (int i = 0; i < NUM_LINES; i++) begin
            if (valid[i] && tags[i] == addr_tag) begin
                any_hit = 1'b1;
                hit_idx = line_idx_t'(i);
            end
        end
    end

    // A write miss merges into a freshly zeroed victim line, so the base word is 0.
    always_comb begin
        target_line = any_hit ? hit_idx : victim;
        stored_word = data[hit_idx][word_sel];
        base_word   = any_hit ? stored_word : '0;
        merged_word = base_word;
        if (byteOP) begin
            merged_word[{byte_sel, 3'b000} +: 8] = data_in[7:0];
        end else begin
            merged_word = data_in;
        end
        read_word = stored_word;
        if (byteOP) begin
            read_word = {{(WORD_WIDTH-8){1'b0}}, stored_word[{byte_sel, 3'b000} +: 8]};
        end
    end

    cache_lru u_lru (
        .clk        (clk),
        .reset      (reset),
        .touch      (access && (any_hit || !is_read)),
        .touch_line (target_line),
        .valid      (valid),
        .victim     (victim)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid    <= '0;
            data_out <= '0;
            hit      <= 1'b0;
            miss     <= 1'b0;
            for (int i = 0; i < NUM_LINES; i++) begin
                tags[i] <= '0;
                for (int w = 0; w < WORDS_PER_LINE; w++) begin
                    data[i][w] <= '0;
                end
            end
        end else if (!access) begin
            hit  <= 1'b0;
            miss <= 1'b0;
        end else begin
            hit  <= any_hit;
            miss <= !any_hit;
            if (is_read) begin
                data_out <= any_hit ? read_word : '0;
            end else begin
                if (!any_hit) begin
                    tags[victim]  <= addr_tag;
                    valid[victim] <= 1'b1;
                    for (int w = 0; w < WORDS_PER_LINE; w++) begin
                        data[victim][w] <= '0;
                    end
                end
                data[target_line][word_sel] <= merged_word;
            end
        end
    end

endmodule

// File: tb/tb_cache.sv
// tb/tb_cache.sv - directed self-checking bench for the data cache
module tb_cache;

    logic        clk;
    logic        reset;
    logic        access;
    logic [31:0] address;
    logic        byteOP;
    logic [31:0] data_in;
    logic        op;
    logic [31:0] data_out;
    logic        hit;
    logic        miss;

    int pass_count;
    int total_count;

    cache dut (
        .clk      (clk),
        .reset    (reset),
        .access   (access),
        .address  (address),
        .byteOP   (byteOP),
        .data_in  (data_in),
        .op       (op),
        .data_out (data_out),
        .hit      (hit),
        .miss     (miss)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic drive(input logic [31:0] a, input logic b, input logic [31:0] d, input logic o);
        access  = 1'b1;
        address = a;
        byteOP  = b;
        data_in = d;
        op      = o;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        access = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        access = 1'b0;
        reset  = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic test_reset();
        access = 1'b0; address = '0; byteOP = 1'b0; data_in = '0; op = 1'b0;
        reset = 1'b0;
        #2 reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        total_count++;
        if ({data_out, hit, miss} !== 34'd0) $display("FAIL reset_outputs: got data_out=%h hit=%b miss=%b, want 0/0/0", data_out, hit, miss);
        else pass_count++;
        reset = 1'b0;
    endtask

    task automatic test_write_hold();
        drive(32'h4, 1'b0, 32'h11, 1'b0);
        total_count++;
        if ({hit, miss} !== 2'b01) $display("FAIL hold_cycle1: got hit=%b miss=%b, want 0/1", hit, miss);
        else pass_count++;
        drive(32'h4, 1'b0, 32'h11, 1'b0);
        total_count++;
        if ({hit, miss} !== 2'b10) $display("FAIL hold_cycle2: got hit=%b miss=%b, want 1/0", hit, miss);
        else pass_count++;
    endtask

    task automatic test_read();
        drive(32'h4, 1'b0, 32'h0, 1'b1);
        total_count++;
        if ({hit, miss, data_out} !== {2'b10, 32'h11}) $display("FAIL word_read: got hit=%b miss=%b data=%h, want 1/0/00000011", hit, miss, data_out);
        else pass_count++;
        drive(32'h4, 1'b1, 32'h0, 1'b1);
        total_count++;
        if ({hit, data_out} !== {1'b1, 32'h11}) $display("FAIL byte_read: got hit=%b data=%h, want 1/00000011", hit, data_out);
        else pass_count++;
    endtask

    task automatic test_byte_write();
        drive(32'h6, 1'b1, 32'hFFFF_FF22, 1'b0);
        total_count++;
        if ({hit, miss} !== 2'b10) $display("FAIL byte_write_hit: got hit=%b miss=%b, want 1/0", hit, miss);
        else pass_count++;
        drive(32'h4, 1'b0, 32'h0, 1'b1);
        total_count++;
        if (data_out !== 32'h0022_0011) $display("FAIL merged_word: got %h, want 00220011", data_out);
        else pass_count++;
        drive(32'h6, 1'b1, 32'h0, 1'b1);
        total_count++;
        if (data_out !== 32'h22) $display("FAIL byte_extract: got %h, want 00000022", data_out);
        else pass_count++;
        drive(32'h0, 1'b0, 32'h0, 1'b1);
        total_count++;
        if ({hit, data_out} !== {1'b1, 32'h0}) $display("FAIL zeroed_word: got hit=%b data=%h, want 1/00000000", hit, data_out);
        else pass_count++;
    endtask

    task automatic test_idle();
        drive(32'h4, 1'b0, 32'h0, 1'b1);
        idle();
        total_count++;
        if ({hit, miss, data_out} !== {2'b00, 32'h0022_0011}) $display("FAIL idle_hold: got hit=%b miss=%b data=%h, want 0/0/00220011", hit, miss, data_out);
        else pass_count++;
        drive(32'h100, 1'b0, 32'h0, 1'b1);
        total_count++;
        if ({hit, miss, data_out} !== {2'b01, 32'h0}) $display("FAIL read_miss: got hit=%b miss=%b data=%h, want 0/1/0", hit, miss, data_out);
        else pass_count++;
    endtask

    task automatic test_evict_lru();
        apply_reset();
        for (int i = 0; i < 4; i++) drive(32'h10 * i, 1'b0, 32'hA0 + i, 1'b0);
        drive(32'h40, 1'b0, 32'hB0, 1'b0);
        total_count++;
        if ({hit, miss} !== 2'b01) $display("FAIL evict_write_miss: got hit=%b miss=%b, want 0/1", hit, miss);
        else pass_count++;
        drive(32'h0, 1'b0, 32'h0, 1'b1);
        total_count++;
        if ({hit, miss, data_out} !== {2'b01, 32'h0}) $display("FAIL evicted_line0: got hit=%b miss=%b data=%h, want 0/1/0", hit, miss, data_out);
        else pass_count++;
        drive(32'h10, 1'b0, 32'h0, 1'b1);
        total_count++;
        if ({hit, data_out} !== {1'b1, 32'hA1}) $display("FAIL kept_line10: got hit=%b data=%h, want 1/000000a1", hit, data_out);
        else pass_count++;
        drive(32'h40, 1'b0, 32'h0, 1'b1);
        total_count++;
        if ({hit, data_out} !== {1'b1, 32'hB0}) $display("FAIL new_line40: got hit=%b data=%h, want 1/000000b0", hit, data_out);
        else pass_count++;
    endtask

    task automatic test_evict_after_use();
        apply_reset();
        for (int i = 0; i < 4; i++) drive(32'h10 * i, 1'b0, 32'hC0 + i, 1'b0);
        drive(32'h0, 1'b0, 32'h0, 1'b1);
        drive(32'h40, 1'b0, 32'hD0, 1'b0);
        drive(32'h10, 1'b0, 32'h0, 1'b1);
        total_count++;
        if ({hit, miss, data_out} !== {2'b01, 32'h0}) $display("FAIL evicted_line10: got hit=%b miss=%b data=%h, want 0/1/0", hit, miss, data_out);
        else pass_count++;
        drive(32'h0, 1'b0, 32'h0, 1'b1);
        total_count++;
        if ({hit, data_out} !== {1'b1, 32'hC0}) $display("FAIL used_line00: got hit=%b data=%h, want 1/000000c0", hit, data_out);
        else pass_count++;
        drive(32'h20, 1'b0, 32'h0, 1'b1);
        total_count++;
        if ({hit, data_out} !== {1'b1, 32'hC2}) $display("FAIL kept_line20: got hit=%b data=%h, want 1/000000c2", hit, data_out);
        else pass_count++;
    endtask

    task automatic test_reset_mid_access();
        apply_reset();
        drive(32'h4, 1'b0, 32'h11, 1'b0);
        drive(32'h4, 1'b0, 32'h0, 1'b1);
        #3 reset = 1'b1;
        #1;
        total_count++;
        if ({data_out, hit, miss} !== 34'd0) $display("FAIL async_reset: got data_out=%h hit=%b miss=%b, want 0/0/0", data_out, hit, miss);
        else pass_count++;
        @(posedge clk);
        #1;
        total_count++;
        if ({data_out, hit, miss} !== 34'd0) $display("FAIL reset_held: got data_out=%h hit=%b miss=%b, want 0/0/0", data_out, hit, miss);
        else pass_count++;
        reset = 1'b0;
        drive(32'h4, 1'b0, 32'h0, 1'b1);
        total_count++;
        if ({hit, miss, data_out} !== {2'b01, 32'h0}) $display("FAIL post_reset_read: got hit=%b miss=%b data=%h, want 0/1/0", hit, miss, data_out);
        else pass_count++;
        idle();
    endtask

    initial begin
        pass_count  = 0;
        total_count = 0;
        test_reset();
        test_write_hold();
        test_read();
        test_byte_write();
        test_idle();
        test_evict_lru();
        test_evict_after_use();
        test_reset_mid_access();
        $display("%0d/%0d checks passed", pass_count, total_count);
        $finish;
    end

endmodule
